ball_serve: RTL and testbench
=============================

# ball_serve

Serve controller for the pong core. It sits directly downstream of the LFSR random generator and consumes its `rnd_num` word. After game start or after every scored point, it waits a fixed number of frames, then launches the ball from the centre column with a pseudo-random row, vertical speed and direction. The ball-physics block loads the serve state on `serve_valid_o`.

## Interface
Parameters:
- `X_CENTER`, default 320: serve column, driven on `ball_x_o`.
- `Y_MIN`, default 40: lowest legal serve row.
- `Y_RANGE`, default 400: number of legal serve rows (`Y_MIN .. Y_MIN+Y_RANGE-1`).
- `Y_W`, default `$clog2(Y_RANGE)`: width of the random row slice.
- `SERVE_DELAY`, default 60: frame ticks between entering DELAY and serving.
- Width of every random-number port is `` `RND_NUM_W `` from `config.svh`. `` `RND_NUM_W `` ≥ `Y_W+3` is required; elaboration-time assertion.

Ports:
- `clk_i`, input, 1: system clock.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `rnd_num_i`, input, `` `RND_NUM_W ``: LFSR output, changes every cycle.
- `game_start_i`, input, 1: single-cycle pulse that starts a game.
- `frame_tick_i`, input, 1: single-cycle pulse, once per video frame.
- `point_scored_i`, input, 1: single-cycle pulse, ball left the field.
- `scorer_left_i`, input, 1: qualifies `point_scored_i`; 1 means the left player scored.
- `ball_x_o`, output, 11: serve column.
- `ball_y_o`, output, 11: serve row.
- `ball_dx_neg_o`, output, 1: horizontal direction; 1 means moving left.
- `ball_dy_o`, output, 3 signed: vertical velocity, one of ±1, ±2.
- `serve_valid_o`, output, 1: one-cycle pulse; serve outputs are valid.
- `ball_active_o`, output, 1: ball is in play.

## Operation
- FSM states: IDLE, DELAY, SERVE, PLAY.
  - IDLE → DELAY on `game_start_i`. On this transition, `first_serve` ← 1 and the frame counter ← `SERVE_DELAY`.
  - DELAY: on `frame_tick_i`, if counter = 0, go to SERVE; otherwise decrement the counter.
  - SERVE → PLAY unconditionally after 1 cycle.
  - PLAY → DELAY on `point_scored_i`. On this transition, the counter ← `SERVE_DELAY`, `first_serve` ← 0, and `serve_left` ← `~scorer_left_i`. The serve goes toward the player who conceded.
- Outputs are captured from `rnd_num_i` on the DELAY→SERVE edge only. They hold until the next serve.
  - Row: `v = rnd_num_i[Y_W-1:0]`. If `v ≥ Y_RANGE`, then `v -= Y_RANGE`. `ball_y_o = Y_MIN + v`. This fold needs a single subtraction, because `2^Y_W < 2*Y_RANGE`.
  - Vertical speed: magnitude = `1 + rnd_num_i[Y_W]`. Sign is negative when `rnd_num_i[Y_W+1]` = 1.
  - Horizontal direction: `ball_dx_neg_o = rnd_num_i[Y_W+2]` if `first_serve`, otherwise `serve_left`.
  - `ball_x_o = X_CENTER`.
- `serve_valid_o` = (state == SERVE). `ball_active_o` = (state == SERVE or PLAY).
- Events ignored by state:
  - `game_start_i` outside IDLE is ignored.
  - `point_scored_i` outside PLAY is ignored.
  - `frame_tick_i` outside DELAY is ignored.
- Simultaneous events: in PLAY, if `point_scored_i` and `frame_tick_i` arrive together, the point is taken and the tick does not count toward the delay.

## Timing
- Reset values: state IDLE; counter 0; `first_serve` 1; `serve_left` 0; `ball_x_o` = `X_CENTER`; `ball_y_o` = `Y_MIN`; `ball_dx_neg_o` 0; `ball_dy_o` = +1; `serve_valid_o` 0; `ball_active_o` 0.
- Reset asserted mid-game forces IDLE immediately; no pulse on `serve_valid_o` is emitted.
- Delay: the serve happens on the (`SERVE_DELAY`+1)-th frame tick after entering DELAY. With `SERVE_DELAY` = 0, the first tick serves.
- `serve_valid_o` rises one cycle after the qualifying tick and lasts exactly 1 cycle. The outputs are valid in that same cycle.
- The counter is `$clog2(SERVE_DELAY+1)` bits wide and never wraps, since it is reloaded on every entry to DELAY.

## Structure
- Shared package `pong_pkg` holds:
  - the `serve_state_e` enum (IDLE, DELAY, SERVE, PLAY);
  - the `BALL_DY_W` = 3 constant;
  - `localparam`s for coordinate width (11).
- One sub-module is natural: `serve_map`, purely combinational. It maps `rnd_num`, `first_serve` and `serve_left` to row, dy and dx. The FSM, counter and output registers stay in `ball_serve`.

## Test plan
Defaults apply: `Y_MIN`=40, `Y_RANGE`=400, `Y_W`=9, `` `RND_NUM_W ``=16, `SERVE_DELAY`=2.
- Start pulse, then 3 ticks, with `rnd_num_i` = 16'h0A64 at capture → `serve_valid_o` for 1 cycle, one cycle after the 3rd tick.
  - Low 9 bits = 100 → `ball_y_o` = 140.
  - Bit 9 = 1 and bit 10 = 0 → `ball_dy_o` = +2.
  - Bit 11 = 1 → `ball_dx_neg_o` = 1.
  - `ball_x_o` = 320.
- Fold: `rnd_num_i` low 9 bits = 450 → `ball_y_o` = 90. Low 9 bits = 511 → `ball_y_o` = 151.
- In PLAY, `point_scored_i` with `scorer_left_i`=1, then 3 ticks → `ball_dx_neg_o` = 0, regardless of `rnd_num_i` bit 11.
- `point_scored_i` during DELAY, and `game_start_i` during PLAY → no state change and no extra `serve_valid_o` pulse.
- `point_scored_i` and `frame_tick_i` in the same cycle, then 2 ticks → no serve; a 3rd tick → serve.
- `rst_i` asserted asynchronously mid-DELAY → `ball_active_o` = 0 and outputs at reset values before the next clock edge; a new start is needed before any further serve.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong core.
// RND_NUM_W normally comes from the project configuration; 16 is the fallback width.
`ifndef RND_NUM_W
`define RND_NUM_W 16
`endif

package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SERVE = 2'd2,
        PLAY  = 2'd3
    } serve_state_e;

    localparam int BALL_DY_W = 3;
    localparam int COORD_W   = 11;

endpackage

// File: rtl/ball_serve_map.sv
// Combinational mapping of a random word to serve row, vertical speed and direction.
// Zero latency; no flow control.
module serve_map
    import pong_pkg::*;
#(
    parameter int Y_MIN   = 40,
    parameter int Y_RANGE = 400,
    parameter int Y_W     = 9
) (
    input  logic [Y_W+2:0]                i_rnd,
    input  logic                          i_first_serve,
    input  logic                          i_serve_left,
    output logic [COORD_W-1:0]            o_ball_y,
    output logic signed [BALL_DY_W-1:0]   o_ball_dy,
    output logic                          o_ball_dx_neg
);

    logic [COORD_W-1:0]          w_v;
    logic [COORD_W-1:0]          w_fold;
    logic signed [BALL_DY_W-1:0] w_mag;

    // 2^Y_W < 2*Y_RANGE, so one conditional subtraction brings v into range.
    assign w_v    = COORD_W'(i_rnd[Y_W-1:0]);
    assign w_fold = (w_v >= COORD_W'(Y_RANGE)) ? (w_v - COORD_W'(Y_RANGE)) : w_v;
    assign o_ball_y = COORD_W'(Y_MIN) + w_fold;

    assign w_mag     = i_rnd[Y_W] ? BALL_DY_W'(2) : BALL_DY_W'(1);
    assign o_ball_dy = i_rnd[Y_W+1] ? -w_mag : w_mag;

    assign o_ball_dx_neg = i_first_serve ? i_rnd[Y_W+2] : i_serve_left;

endmodule

// File: rtl/ball_serve.sv
// Serve controller: waits SERVE_DELAY+1 frame ticks after start/point, then launches the ball.
// Serve outputs are captured on the serving tick and valid with the one-cycle serve_valid_o pulse.
module ball_serve
    import pong_pkg::*;
#(
    parameter int X_CENTER    = 320,
    parameter int Y_MIN       = 40,
    parameter int Y_RANGE     = 400,
    parameter int Y_W         = $clog2(Y_RANGE),
    parameter int SERVE_DELAY = 60
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [`RND_NUM_W-1:0]         rnd_num_i,
    input  logic                          game_start_i,
    input  logic                          frame_tick_i,
    input  logic                          point_scored_i,
    input  logic                          scorer_left_i,
    output logic [COORD_W-1:0]            ball_x_o,
    output logic [COORD_W-1:0]            ball_y_o,
    output logic                          ball_dx_neg_o,
    output logic signed [BALL_DY_W-1:0]   ball_dy_o,
    output logic                          serve_valid_o,
    output logic                          ball_active_o
);

    localparam int CNT_W = (SERVE_DELAY > 0) ? $clog2(SERVE_DELAY + 1) : 1;
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(SERVE_DELAY);

    generate
        if (`RND_NUM_W < Y_W + 3) begin : g_rnd_w_check
            $error("ball_serve: RND_NUM_W must be at least Y_W+3");
        end
        if (`RND_NUM_W > Y_W + 3) begin : g_rnd_unused
            logic w_unused_rnd;
            assign w_unused_rnd = ^rnd_num_i[`RND_NUM_W-1:Y_W+3];
        end
    endgenerate

    serve_state_e r_state;
    serve_state_e w_next_state;

    logic [CNT_W-1:0]            r_cnt;
    logic                        r_first_serve;
    logic                        r_serve_left;
    logic [COORD_W-1:0]          r_ball_y;
    logic signed [BALL_DY_W-1:0] r_ball_dy;
    logic                        r_ball_dx_neg;

    logic                        w_start;
    logic                        w_point;
    logic                        w_cnt_zero;
    logic                        w_capture;
    logic [COORD_W-1:0]          w_map_y;
    logic signed [BALL_DY_W-1:0] w_map_dy;
    logic                        w_map_dx_neg;

    assign w_start    = (r_state == IDLE) && game_start_i;
    assign w_point    = (r_state == PLAY) && point_scored_i;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_capture  = (r_state == DELAY) && frame_tick_i && w_cnt_zero;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (game_start_i)   w_next_state = DELAY;
            DELAY:   if (w_capture)      w_next_state = SERVE;
            SERVE:                       w_next_state = PLAY;
            PLAY:    if (point_scored_i) w_next_state = DELAY;
            default:                     w_next_state = IDLE;
        endcase
    end

    always_comb begin
        serve_valid_o = (r_state == SERVE);
        ball_active_o = (r_state == SERVE) || (r_state == PLAY);
    end

    // Counter is reloaded on every entry to DELAY, so it only ever counts down.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt         <= '0;
            r_first_serve <= 1'b1;
            r_serve_left  <= 1'b0;
        end else if (w_start) begin
            r_cnt         <= DELAY_LOAD;
            r_first_serve <= 1'b1;
        end else if (w_point) begin
            r_cnt         <= DELAY_LOAD;
            r_first_serve <= 1'b0;
            r_serve_left  <= ~scorer_left_i;
        end else if ((r_state == DELAY) && frame_tick_i && !w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    serve_map #(
        .Y_MIN   (Y_MIN),
        .Y_RANGE (Y_RANGE),
        .Y_W     (Y_W)
    ) u_serve_map (
        .i_rnd         (rnd_num_i[Y_W+2:0]),
        .i_first_serve (r_first_serve),
        .i_serve_left  (r_serve_left),
        .o_ball_y      (w_map_y),
        .o_ball_dy     (w_map_dy),
        .o_ball_dx_neg (w_map_dx_neg)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ball_y      <= COORD_W'(Y_MIN);
            r_ball_dy     <= BALL_DY_W'(1);
            r_ball_dx_neg <= 1'b0;
        end else if (w_capture) begin
            r_ball_y      <= w_map_y;
            r_ball_dy     <= w_map_dy;
            r_ball_dx_neg <= w_map_dx_neg;
        end
    end

    assign ball_x_o      = COORD_W'(X_CENTER);
    assign ball_y_o      = r_ball_y;
    assign ball_dy_o     = r_ball_dy;
    assign ball_dx_neg_o = r_ball_dx_neg;

endmodule

// File: tb/tb_ball_serve.sv
// Self-checking bench for ball_serve with SERVE_DELAY=2 and randomized rnd_num stimulus.
`ifndef RND_NUM_W
`define RND_NUM_W 16
`endif

module tb_ball_serve;

    localparam int RW  = `RND_NUM_W;
    localparam int YW  = 9;
    localparam int SD  = 2;

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_SERVE = 2;
    localparam int P_PLAY  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [RW-1:0]     rnd;
    logic              start, tick, point, scorer;
    logic [10:0]       bx, by;
    logic              dxn;
    logic signed [2:0] dy;
    logic              sv, act;

    int checks = 0;
    int errors = 0;

    // Reference model: phase, ticks still owed, and the serve expected to be on the outputs.
    int                m_phase;
    int                m_left;
    bit                m_first;
    bit                m_dxl;
    int                e_y;
    logic signed [2:0] e_dy;
    logic              e_dx;

    ball_serve #(
        .X_CENTER    (320),
        .Y_MIN       (40),
        .Y_RANGE     (400),
        .Y_W         (YW),
        .SERVE_DELAY (SD)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rnd_num_i      (rnd),
        .game_start_i   (start),
        .frame_tick_i   (tick),
        .point_scored_i (point),
        .scorer_left_i  (scorer),
        .ball_x_o       (bx),
        .ball_y_o       (by),
        .ball_dx_neg_o  (dxn),
        .ball_dy_o      (dy),
        .serve_valid_o  (sv),
        .ball_active_o  (act)
    );

    always #5 clk = ~clk;

    function automatic int ref_y(input logic [RW-1:0] r);
        int v;
        v = int'(r[YW-1:0]);
        return 40 + (v % 400);
    endfunction

    function automatic logic signed [2:0] ref_dy(input logic [RW-1:0] r);
        int m;
        m = r[YW] ? 2 : 1;
        if (r[YW+1]) m = -m;
        return 3'(m);
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_left  = 0;
        m_first = 1'b1;
        m_dxl   = 1'b0;
        e_y     = 40;
        e_dy    = 3'sd1;
        e_dx    = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        bit want_sv, want_act;
        want_sv  = (m_phase == P_SERVE);
        want_act = (m_phase == P_SERVE) || (m_phase == P_PLAY);
        checks++;
        if (sv !== want_sv) begin
            errors++;
            $display("FAIL %s serve_valid: got %b want %b at %0t", tag, sv, want_sv, $time);
        end
        checks++;
        if (act !== want_act) begin
            errors++;
            $display("FAIL %s ball_active: got %b want %b at %0t", tag, act, want_act, $time);
        end
        checks++;
        if (bx !== 11'd320) begin
            errors++;
            $display("FAIL %s ball_x: got %0d want 320 at %0t", tag, bx, $time);
        end
        checks++;
        if (by !== 11'(e_y)) begin
            errors++;
            $display("FAIL %s ball_y: got %0d want %0d at %0t", tag, by, e_y, $time);
        end
        checks++;
        if (dy !== e_dy) begin
            errors++;
            $display("FAIL %s ball_dy: got %0d want %0d at %0t", tag, dy, e_dy, $time);
        end
        checks++;
        if (dxn !== e_dx) begin
            errors++;
            $display("FAIL %s ball_dx_neg: got %b want %b at %0t", tag, dxn, e_dx, $time);
        end
    endtask

    // One clock with the inputs currently driven; model advances on the same inputs.
    task automatic step();
        case (m_phase)
            P_IDLE: if (start) begin
                m_phase = P_WAIT; m_left = SD + 1; m_first = 1'b1;
            end
            P_WAIT: if (tick) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = P_SERVE;
                    e_y  = ref_y(rnd);
                    e_dy = ref_dy(rnd);
                    e_dx = m_first ? rnd[YW+2] : m_dxl;
                end
            end
            P_SERVE: m_phase = P_PLAY;
            default: if (point) begin
                m_phase = P_WAIT; m_left = SD + 1; m_first = 1'b0; m_dxl = ~scorer;
            end
        endcase
        @(posedge clk);
        #1;
        start = 1'b0; tick = 1'b0; point = 1'b0;
        rnd   = RW'($urandom);
        check_outputs("step");
    endtask

    // n frame ticks separated by random idle gaps; optionally force rnd on the last tick.
    task automatic ticks(input int n, input logic [RW-1:0] last_rnd, input bit use_last);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            tick = 1'b1;
            if (use_last && i == n - 1) rnd = last_rnd;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; tick = 0; point = 0; scorer = 0; rnd = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;
        step();
    endtask

    task automatic test_first_serve();
        logic signed [2:0] want_dy;
        want_dy = 3'sd2;
        start = 1'b1;
        step();
        ticks(3, RW'(16'h0A64), 1'b1);
        checks++;
        if (sv !== 1'b1 || by !== 11'd140 || dy !== want_dy || dxn !== 1'b1 || bx !== 11'd320) begin
            errors++;
            $display("FAIL first_serve: got v=%b y=%0d dy=%0d dx=%b x=%0d want v=1 y=140 dy=2 dx=1 x=320",
                     sv, by, dy, dxn, bx);
        end
        step();
        checks++;
        if (sv !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: serve_valid got %b want 0", sv);
        end
    endtask

    task automatic test_fold();
        logic [RW-1:0] r;
        point = 1'b1; scorer = 1'($urandom);
        step();
        r = RW'($urandom); r[YW-1:0] = 9'd450;
        ticks(3, r, 1'b1);
        checks++;
        if (by !== 11'd90) begin
            errors++;
            $display("FAIL fold_450: ball_y got %0d want 90", by);
        end
        step();
        point = 1'b1; scorer = 1'($urandom);
        step();
        r = RW'($urandom); r[YW-1:0] = 9'd511;
        ticks(3, r, 1'b1);
        checks++;
        if (by !== 11'd151) begin
            errors++;
            $display("FAIL fold_511: ball_y got %0d want 151", by);
        end
        step();
    endtask

    task automatic test_point_dir();
        logic [RW-1:0] r;
        point = 1'b1; scorer = 1'b1;
        step();
        r = RW'($urandom); r[YW+2] = 1'b1;
        ticks(3, r, 1'b1);
        checks++;
        if (dxn !== 1'b0) begin
            errors++;
            $display("FAIL dir_left_scored: ball_dx_neg got %b want 0", dxn);
        end
        step();
        point = 1'b1; scorer = 1'b0;
        step();
        r = RW'($urandom); r[YW+2] = 1'b0;
        ticks(3, r, 1'b1);
        checks++;
        if (dxn !== 1'b1) begin
            errors++;
            $display("FAIL dir_right_scored: ball_dx_neg got %b want 1", dxn);
        end
        step();
    endtask

    task automatic test_ignored();
        point = 1'b1; scorer = 1'b1;
        step();
        point = 1'b1; step();
        start = 1'b1; step();
        tick = 1'b1; point = 1'b1; step();
        ticks(2, '0, 1'b0);
        checks++;
        if (sv !== 1'b1) begin
            errors++;
            $display("FAIL ignored_in_delay: serve_valid got %b want 1", sv);
        end
        step();
        start = 1'b1; step();
        tick = 1'b1; step();
        checks++;
        if (act !== 1'b1 || sv !== 1'b0) begin
            errors++;
            $display("FAIL ignored_in_play: active=%b valid=%b want active=1 valid=0", act, sv);
        end
    endtask

    task automatic test_simul();
        point = 1'b1; tick = 1'b1; scorer = 1'($urandom);
        step();
        ticks(2, '0, 1'b0);
        checks++;
        if (sv !== 1'b0) begin
            errors++;
            $display("FAIL simul_early: serve_valid got %b want 0", sv);
        end
        ticks(1, '0, 1'b0);
        checks++;
        if (sv !== 1'b1) begin
            errors++;
            $display("FAIL simul_third_tick: serve_valid got %b want 1", sv);
        end
        step();
    endtask

    task automatic test_async_reset();
        logic [RW-1:0] r;
        point = 1'b1; step();
        tick = 1'b1; step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        ticks(4, '0, 1'b0);
        checks++;
        if (act !== 1'b0) begin
            errors++;
            $display("FAIL reset_needs_start: ball_active got %b want 0", act);
        end
        start = 1'b1; step();
        r = RW'($urandom); r[YW+2] = 1'b1;
        ticks(3, r, 1'b1);
        checks++;
        if (sv !== 1'b1 || dxn !== 1'b1) begin
            errors++;
            $display("FAIL restart_first_serve: valid=%b dx=%b want valid=1 dx=1", sv, dxn);
        end
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            start  = ($urandom_range(0, 7) == 0);
            point  = ($urandom_range(0, 5) == 0);
            tick   = ($urandom_range(0, 2) == 0);
            scorer = 1'($urandom);
            step();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_serve();
        test_fold();
        test_point_dir();
        test_ignored();
        test_simul();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
